// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the VGA raster timing generator.
// Defaults describe a 640x480 frame driven from a 50 MHz system clock.
package vga_timing_pkg;

    localparam int unsigned DEF_H_PULSE = 192;
    localparam int unsigned DEF_H_BP    = 96;
    localparam int unsigned DEF_H_DISP  = 1280;
    localparam int unsigned DEF_H_FP    = 32;
    localparam int unsigned DEF_V_PULSE = 2;
    localparam int unsigned DEF_V_BP    = 29;
    localparam int unsigned DEF_V_DISP  = 480;
    localparam int unsigned DEF_V_FP    = 10;
    localparam int unsigned DEF_H_DIV   = 10;
    localparam int unsigned DEF_V_DIV   = 5;
    localparam int unsigned DEF_HPIX_W  = 7;
    localparam int unsigned DEF_VPIX_W  = 7;

    function automatic int unsigned axis_total(input int unsigned pulse, input int unsigned bp,
                                               input int unsigned disp, input int unsigned fp);
        return pulse + bp + disp + fp;
    endfunction

    function automatic int unsigned h_total(input int unsigned pulse, input int unsigned bp,
                                            input int unsigned disp, input int unsigned fp);
        return axis_total(pulse, bp, disp, fp);
    endfunction

    function automatic int unsigned v_total(input int unsigned pulse, input int unsigned bp,
                                            input int unsigned disp, input int unsigned fp);
        return axis_total(pulse, bp, disp, fp);
    endfunction

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_H_TOTAL = h_total(DEF_H_PULSE, DEF_H_BP, DEF_H_DISP, DEF_H_FP);
    localparam int unsigned DEF_V_TOTAL = v_total(DEF_V_PULSE, DEF_V_BP, DEF_V_DISP, DEF_V_FP);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with sync, active window, divided pixel index
// and wrap strobe. All outputs are registered and decode the current position.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned PULSE = DEF_H_PULSE,
    parameter int unsigned BP    = DEF_H_BP,
    parameter int unsigned DISP  = DEF_H_DISP,
    parameter int unsigned FP    = DEF_H_FP,
    parameter int unsigned DIV   = DEF_H_DIV,
    parameter int unsigned PIX_W = DEF_HPIX_W,
    parameter bit          POL   = 1'b0
) (
    input  logic             clk,
    input  logic             resetbutton,
    input  logic             step,
    input  logic             qual,
    output logic             sync,
    output logic             active,
    output logic [PIX_W-1:0] pix,
    output logic             wrap,
    output logic             wrap_next
);

    localparam int unsigned TOTAL = axis_total(PULSE, BP, DISP, FP);
    localparam int unsigned CW    = cnt_width(TOTAL);
    localparam int unsigned SW    = cnt_width(DIV);

    localparam logic [CW-1:0] LAST      = CW'(TOTAL - 1);
    localparam logic [CW-1:0] PULSE_END = CW'(PULSE);
    localparam logic [CW-1:0] ACT_START = CW'(PULSE + BP);
    localparam logic [CW-1:0] ACT_END   = CW'(PULSE + BP + DISP);
    localparam logic [SW-1:0] SUB_LAST  = SW'(DIV - 1);

    generate
        if (PULSE == 0 || BP == 0 || DISP == 0 || FP == 0) begin : g_bad_zero
            $error("vga_axis_counter: pulse and porch widths must be non-zero");
        end
        if (DIV == 0) begin : g_bad_div
            $error("vga_axis_counter: divider must be non-zero");
        end else if (DISP % DIV != 0) begin : g_bad_mod
            $error("vga_axis_counter: active width not divisible by divider");
        end else if (64'(DISP / DIV) > (64'd1 << PIX_W)) begin : g_bad_pix
            $error("vga_axis_counter: pixel index width too small");
        end
    endgenerate

    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [SW-1:0]    sub_reg, sub_next;
    logic [PIX_W-1:0] pix_reg, pix_next;
    logic             act_next;

    always_comb begin
        wrap_next = step && (cnt_reg == LAST);
        cnt_next  = cnt_reg;
        sub_next  = sub_reg;
        pix_next  = pix_reg;
        if (step) begin
            cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
        end
        act_next = (cnt_next >= ACT_START) && (cnt_next < ACT_END);
        // The index restarts on the first active position and only moves while
        // inside the window, so it never overflows within one pass.
        if (step) begin
            if (cnt_next == ACT_START) begin
                sub_next = '0;
                pix_next = '0;
            end else if (act_next) begin
                if (sub_reg == SUB_LAST) begin
                    sub_next = '0;
                    pix_next = pix_reg + PIX_W'(1);
                end else begin
                    sub_next = sub_reg + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge resetbutton) begin
        if (resetbutton) begin
            cnt_reg <= '0;
            sub_reg <= '0;
            pix_reg <= '0;
            sync    <= POL;
            active  <= 1'b0;
            pix     <= '0;
            wrap    <= 1'b0;
        end else begin
            wrap <= wrap_next;
            if (step) begin
                cnt_reg <= cnt_next;
                sub_reg <= sub_next;
                pix_reg <= pix_next;
                sync    <= (cnt_next < PULSE_END) ? POL : ~POL;
                active  <= act_next & qual;
                pix     <= (act_next & qual) ? pix_next : '0;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal and vertical axes, active-video window,
// logical pixel coordinates and line/frame strobes, all registered and skew-free.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_PULSE   = DEF_H_PULSE,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned H_DISP    = DEF_H_DISP,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned V_PULSE   = DEF_V_PULSE,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter int unsigned V_DISP    = DEF_V_DISP,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned H_DIV     = DEF_H_DIV,
    parameter int unsigned V_DIV     = DEF_V_DIV,
    parameter int unsigned HPIX_W    = DEF_HPIX_W,
    parameter int unsigned VPIX_W    = DEF_VPIX_W,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              resetbutton,
    input  logic              en,
    output logic              VGA_HSYNC,
    output logic              VGA_VSYNC,
    output logic [HPIX_W-1:0] HPIXEL,
    output logic [VPIX_W-1:0] VPIXEL,
    output logic              display_en,
    output logic              line_start,
    output logic              frame_start
);

    logic h_wrap_next;
    logic v_active;
    logic v_wrap_next_unused;

    // The vertical active flag only changes on the edge where the horizontal axis
    // returns to 0 (outside its window), so its registered value is a safe qualifier.
    vga_axis_counter #(
        .PULSE (H_PULSE),
        .BP    (H_BP),
        .DISP  (H_DISP),
        .FP    (H_FP),
        .DIV   (H_DIV),
        .PIX_W (HPIX_W),
        .POL   (HSYNC_POL)
    ) u_h_axis (
        .clk         (clk),
        .resetbutton (resetbutton),
        .step        (en),
        .qual        (v_active),
        .sync        (VGA_HSYNC),
        .active      (display_en),
        .pix         (HPIXEL),
        .wrap        (line_start),
        .wrap_next   (h_wrap_next)
    );

    // A vertical wrap can only coincide with a horizontal wrap, so its strobe is frame_start.
    vga_axis_counter #(
        .PULSE (V_PULSE),
        .BP    (V_BP),
        .DISP  (V_DISP),
        .FP    (V_FP),
        .DIV   (V_DIV),
        .PIX_W (VPIX_W),
        .POL   (VSYNC_POL)
    ) u_v_axis (
        .clk         (clk),
        .resetbutton (resetbutton),
        .step        (h_wrap_next),
        .qual        (1'b1),
        .sync        (VGA_VSYNC),
        .active      (v_active),
        .pix         (VPIXEL),
        .wrap        (frame_start),
        .wrap_next   (v_wrap_next_unused)
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a default-parameter instance for line timing and a small
// instance for frame wrap, enable gating and asynchronous mid-frame reset.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic resetbutton;
    logic en_d, en_s;

    logic       hs_d, vs_d, de_d, ls_d, fs_d;
    logic [6:0] hp_d, vp_d;
    logic       hs_s, vs_s, de_s, ls_s, fs_s;
    logic [6:0] hp_s, vp_s;

    int n_cmp = 0;
    int n_err = 0;
    int e_cur = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk         (clk),
        .resetbutton (resetbutton),
        .en          (en_d),
        .VGA_HSYNC   (hs_d),
        .VGA_VSYNC   (vs_d),
        .HPIXEL      (hp_d),
        .VPIXEL      (vp_d),
        .display_en  (de_d),
        .line_start  (ls_d),
        .frame_start (fs_d)
    );

    vga_timing_gen #(
        .H_PULSE(4), .H_BP(2), .H_DISP(16), .H_FP(2),
        .V_PULSE(1), .V_BP(1), .V_DISP(4), .V_FP(1),
        .H_DIV(4), .V_DIV(2), .HPIX_W(7), .VPIX_W(7),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_s (
        .clk         (clk),
        .resetbutton (resetbutton),
        .en          (en_s),
        .VGA_HSYNC   (hs_s),
        .VGA_VSYNC   (vs_s),
        .HPIXEL      (hp_s),
        .VPIXEL      (vp_s),
        .display_en  (de_s),
        .line_start  (ls_s),
        .frame_start (fs_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic adv(input int target);
        tick(target - e_cur);
        e_cur = target;
    endtask

    initial begin
        int n;
        int ls_cnt;
        resetbutton = 1'b1;
        en_d = 1'b0;
        en_s = 1'b0;
        tick(2);
        resetbutton = 1'b0;
        en_d = 1'b1;
        e_cur = 0;

        // Default instance: reset state and horizontal timing
        chk("d_rst_hsync", 32'(hs_d), 0);
        chk("d_rst_vsync", 32'(vs_d), 0);
        chk("d_rst_de", 32'(de_d), 0);
        chk("d_rst_ls", 32'(ls_d), 0);
        chk("d_rst_fs", 32'(fs_d), 0);
        adv(1);     chk("d_first_edge_hsync", 32'(hs_d), 0);
        adv(191);   chk("d_hsync_191", 32'(hs_d), 0);
        adv(192);   chk("d_hsync_192", 32'(hs_d), 1);
        adv(1599);  chk("d_hsync_1599", 32'(hs_d), 1);
                    chk("d_ls_1599", 32'(ls_d), 0);
        adv(1600);  chk("d_ls_line1", 32'(ls_d), 1);
                    chk("d_hsync_line1", 32'(hs_d), 0);
                    chk("d_vsync_line1", 32'(vs_d), 0);
                    chk("d_fs_line1", 32'(fs_d), 0);
        adv(1601);  chk("d_ls_one_cycle", 32'(ls_d), 0);
        adv(3199);  chk("d_vsync_3199", 32'(vs_d), 0);
        adv(3200);  chk("d_vsync_line2", 32'(vs_d), 1);
        adv(48288); chk("d_line30_de", 32'(de_d), 0);
        adv(49887); chk("d_l31_de_287", 32'(de_d), 0);
        adv(49888); chk("d_l31_de_288", 32'(de_d), 1);
                    chk("d_l31_hp_288", 32'(hp_d), 0);
                    chk("d_l31_vp", 32'(vp_d), 0);
        adv(49897); chk("d_l31_hp_297", 32'(hp_d), 0);
        adv(49898); chk("d_l31_hp_298", 32'(hp_d), 1);
        adv(51157); chk("d_l31_hp_1557", 32'(hp_d), 126);
        adv(51158); chk("d_l31_hp_1558", 32'(hp_d), 127);
        adv(51167); chk("d_l31_hp_1567", 32'(hp_d), 127);
                    chk("d_l31_de_1567", 32'(de_d), 1);
        adv(51168); chk("d_l31_de_1568", 32'(de_d), 0);
                    chk("d_l31_hp_1568", 32'(hp_d), 0);
                    chk("d_hsync_1568", 32'(hs_d), 1);

        // Asynchronous reset between edges; both instances respond at once
        #2 resetbutton = 1'b1;
        #1;
        chk("d_async_rst_hsync", 32'(hs_d), 0);
        chk("s_async_rst_hsync", 32'(hs_s), 1);
        chk("s_async_rst_vsync", 32'(vs_s), 1);
        en_s = 1'b1;
        tick(1);
        resetbutton = 1'b0;
        e_cur = 0;

        // Small instance: H total 24, V total 7, frame 168 clks, both polarities high
        chk("s_rst_de", 32'(de_s), 0);
        chk("s_rst_hp", 32'(hp_s), 0);
        chk("s_rst_fs", 32'(fs_s), 0);
        adv(3);   chk("s_hsync_3", 32'(hs_s), 1);
        adv(4);   chk("s_hsync_4", 32'(hs_s), 0);
        adv(23);  chk("s_ls_23", 32'(ls_s), 0);
                  chk("s_vsync_line0", 32'(vs_s), 1);
        adv(24);  chk("s_ls_24", 32'(ls_s), 1);
                  chk("s_fs_24", 32'(fs_s), 0);
                  chk("s_hsync_24", 32'(hs_s), 1);
                  chk("s_vsync_line1", 32'(vs_s), 0);
        adv(53);  chk("s_l2_de_5", 32'(de_s), 0);
        adv(54);  chk("s_l2_de_6", 32'(de_s), 1);
                  chk("s_l2_hp_6", 32'(hp_s), 0);
                  chk("s_l2_vp", 32'(vp_s), 0);
        adv(57);  chk("s_l2_hp_9", 32'(hp_s), 0);
        adv(58);  chk("s_l2_hp_10", 32'(hp_s), 1);
        adv(62);  chk("s_l2_hp_14", 32'(hp_s), 2);
        adv(66);  chk("s_l2_hp_18", 32'(hp_s), 3);
        adv(69);  chk("s_l2_hp_21", 32'(hp_s), 3);
                  chk("s_l2_de_21", 32'(de_s), 1);
        adv(70);  chk("s_l2_de_22", 32'(de_s), 0);
                  chk("s_l2_hp_22", 32'(hp_s), 0);
        adv(102); chk("s_l4_vp", 32'(vp_s), 1);
                  chk("s_l4_de", 32'(de_s), 1);
        adv(150); chk("s_l6_de", 32'(de_s), 0);
                  chk("s_l6_vp", 32'(vp_s), 0);
        adv(167); chk("s_fs_167", 32'(fs_s), 0);
        adv(168); chk("s_fs_168", 32'(fs_s), 1);
                  chk("s_ls_168", 32'(ls_s), 1);
                  chk("s_vsync_wrap", 32'(vs_s), 1);
        adv(169); chk("s_fs_169", 32'(fs_s), 0);

        // Enable gating around a line wrap
        adv(191);
        en_s = 1'b0; tick(1);
        chk("s_hold_ls", 32'(ls_s), 0);
        chk("s_hold_hsync", 32'(hs_s), 0);
        en_s = 1'b1; tick(1);
        chk("s_gated_wrap_ls", 32'(ls_s), 1);
        en_s = 1'b0; tick(1);
        chk("s_no_repeat_ls", 32'(ls_s), 0);
        chk("s_hold_hsync_wrap", 32'(hs_s), 1);
        en_s = 1'b1; tick(1);
        chk("s_ls_after_hold", 32'(ls_s), 0);

        // en alternating 0/1: 23 enabled edges to the next wrap take 46 clks
        n = 0;
        for (int k = 0; k < 100; k++) begin
            en_s = (k % 2 == 1);
            tick(1);
            n++;
            if (ls_s) break;
        end
        chk("s_toggle_line_period", 32'(n), 46);
        en_s = 1'b0; tick(1);
        chk("s_toggle_no_repeat", 32'(ls_s), 0);

        // Mid-frame asynchronous reset while in the active window
        en_s = 1'b1; tick(10);
        chk("s_pre_rst_de", 32'(de_s), 1);
        chk("s_pre_rst_hp", 32'(hp_s), 1);
        #2 resetbutton = 1'b1;
        #1;
        chk("s_mid_rst_de", 32'(de_s), 0);
        chk("s_mid_rst_hp", 32'(hp_s), 0);
        chk("s_mid_rst_hsync", 32'(hs_s), 1);
        chk("s_mid_rst_vsync", 32'(vs_s), 1);
        chk("s_mid_rst_ls", 32'(ls_s), 0);
        tick(1);
        chk("s_rst_held_de", 32'(de_s), 0);
        chk("s_rst_held_hsync", 32'(hs_s), 1);
        resetbutton = 1'b0;

        n = 0;
        ls_cnt = 0;
        for (int k = 0; k < 400; k++) begin
            tick(1);
            n++;
            if (ls_s) ls_cnt++;
            if (fs_s) break;
        end
        chk("s_post_rst_frame_edges", 32'(n), 168);
        chk("s_post_rst_line_count", 32'(ls_cnt), 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
